pipeline_ctrl: RTL and testbench

//  Central sequencer for the 3-stage pipeline (FD, DE, EW). Drives the 2-bit update

---
 rtl/pipeline_ctrl_pkg.sv | 6 +
 rtl/pipeline_ctrl_hazard_detect.sv | 14 +
 rtl/pipeline_ctrl.sv | 81 ++++++++
 tb/tb_pipeline_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipe_pkg: shared pipeline-register update commands, sequencer states and defaults.
package pipe_pkg;
  typedef enum logic [1:0] {UPD_HOLD = 2'd0, UPD_LOAD = 2'd1, UPD_FLUSH = 2'd2} upd_t;
  typedef enum logic [1:0] {RUN = 2'd0, EXEC_WAIT = 2'd1, HALT = 2'd2} ctrl_state_t;
  localparam int WAIT_W_DEF = 5;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: flags a decode source that reads the register the DE instruction writes.
module hazard_detect (
  input  logic [5:0] d_rs,
  input  logic [5:0] d_rt,
  input  logic       d_uses_rs,
  input  logic       d_uses_rt,
  input  logic [1:0] de_rw,
  input  logic [4:0] de_rd,
  output logic       raw
);
  logic [5:0] dst;
  assign dst = {de_rw[1], de_rd};
  assign raw = (|de_rw) && ((d_uses_rs && d_rs == dst) || (d_uses_rt && d_rt == dst));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequences FD/DE/EW update commands and PC control across waits, hazards,
// redirects, external stalls and halt.
module pipeline_ctrl import pipe_pkg::*; #(
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ext_stall,
  input  logic              resume,
  input  logic [5:0]        d_rs,
  input  logic [5:0]        d_rt,
  input  logic              d_uses_rs,
  input  logic              d_uses_rt,
  input  logic [1:0]        de_rw,
  input  logic [4:0]        de_rd,
  input  logic [WAIT_W-1:0] de_wait_time,
  input  logic              de_redirect,
  input  logic              de_stop,
  output logic [1:0]        fd_update,
  output logic [1:0]        de_update,
  output logic [1:0]        ew_update,
  output logic              pc_en,
  output logic              pc_sel,
  output logic              halted,
  output logic              exec_busy
);
  ctrl_state_t       state, state_nx;
  logic [WAIT_W-1:0] cnt, cnt_nx;
  upd_t              fd_u, de_u, ew_u;
  logic              raw, e_done;
  hazard_detect u_hazard (
    .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .de_rw(de_rw), .de_rd(de_rd), .raw(raw)
  );
  // a wait time of 0 completes like 1; cnt<=1 keeps the counter from ever underflowing
  assign e_done = (state == RUN && de_wait_time <= WAIT_W'(1)) ||
                  (state == EXEC_WAIT && cnt <= WAIT_W'(1));
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    fd_u = UPD_HOLD;
    de_u = UPD_HOLD;
    ew_u = UPD_HOLD;
    pc_en = 1'b0;
    pc_sel = 1'b0;
    if (!rstn) begin
      state_nx = RUN;
      cnt_nx = '0;
    end else if (state == HALT) begin
      state_nx = resume ? RUN : HALT;
    end else if (!ext_stall) begin
      if (!e_done) begin
        ew_u = UPD_FLUSH;
        state_nx = EXEC_WAIT;
        cnt_nx = (state == RUN) ? de_wait_time - WAIT_W'(1) : cnt - WAIT_W'(1);
      end else begin
        ew_u = UPD_LOAD;
        state_nx = de_stop ? HALT : RUN;
        cnt_nx = '0;
        fd_u = (de_stop || de_redirect) ? UPD_FLUSH : raw ? UPD_HOLD : UPD_LOAD;
        de_u = (de_stop || de_redirect || raw) ? UPD_FLUSH : UPD_LOAD;
        pc_en = !de_stop && (de_redirect || !raw);
        pc_sel = !de_stop && de_redirect;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  assign fd_update = fd_u;
  assign de_update = de_u;
  assign ew_update = ew_u;
  assign halted = rstn && state == HALT;
  assign exec_busy = rstn && state == EXEC_WAIT;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed literal checks plus randomized traffic against a
// remaining-cycles model of the sequencer.
module tb_pipeline_ctrl;
  logic       clk = 0, rstn = 0, ext_stall = 0, resume = 0;
  logic       d_uses_rs = 0, d_uses_rt = 0, de_redirect = 0, de_stop = 0;
  logic [5:0] d_rs = 0, d_rt = 0;
  logic [1:0] de_rw = 0;
  logic [4:0] de_rd = 0, de_wait_time = 1;
  logic [1:0] fd_update, de_update, ew_update;
  logic       pc_en, pc_sel, halted, exec_busy;
  logic [9:0] act;
  int         checks = 0, errors = 0;
  int         rem = 0;
  bit         m_halt = 0;
  always #5 clk = ~clk;
  pipeline_ctrl dut (
    .clk(clk), .rstn(rstn), .ext_stall(ext_stall), .resume(resume),
    .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .de_rw(de_rw), .de_rd(de_rd), .de_wait_time(de_wait_time),
    .de_redirect(de_redirect), .de_stop(de_stop),
    .fd_update(fd_update), .de_update(de_update), .ew_update(ew_update),
    .pc_en(pc_en), .pc_sel(pc_sel), .halted(halted), .exec_busy(exec_busy)
  );
  assign act = {fd_update, de_update, ew_update, pc_en, pc_sel, halted, exec_busy};
  function automatic logic [9:0] pk(int fd, int de, int ew, int en, int sel, int h, int b);
    return {2'(fd), 2'(de), 2'(ew), 1'(en), 1'(sel), 1'(h), 1'(b)};
  endfunction
  task automatic check(string name, logic [9:0] got, logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got fd/de/ew/en/sel/h/b=%b want %b", name, $time, got, want);
    end
  endtask
  // rem = cycles the DE instruction still needs including the current one; 0 = not started
  always @(negedge clk) begin : model
    logic [9:0] want;
    int left;
    bit hz, busy;
    hz = (de_rw != 2'b00) &&
         ((d_uses_rs && d_rs[5] == de_rw[1] && d_rs[4:0] == de_rd) ||
          (d_uses_rt && d_rt[5] == de_rw[1] && d_rt[4:0] == de_rd));
    busy = rem != 0;
    if (!rstn) begin
      want = '0;
      rem = 0;
      m_halt = 0;
    end else if (m_halt) begin
      want = pk(0, 0, 0, 0, 0, 1, 0);
      if (resume) m_halt = 0;
    end else if (ext_stall) begin
      want = pk(0, 0, 0, 0, 0, 0, int'(busy));
    end else begin
      left = busy ? rem : (de_wait_time == 0 ? 1 : int'(de_wait_time));
      if (left > 1) begin
        want = pk(0, 0, 2, 0, 0, 0, int'(busy));
        rem = left - 1;
      end else begin
        rem = 0;
        if (de_stop) begin
          want = pk(2, 2, 1, 0, 0, 0, int'(busy));
          m_halt = 1;
        end else if (de_redirect) want = pk(2, 2, 1, 1, 1, 0, int'(busy));
        else if (hz) want = pk(0, 2, 1, 0, 0, 0, int'(busy));
        else want = pk(1, 1, 1, 1, 0, 0, int'(busy));
      end
    end
    check("model", act, want);
  end
  task automatic cyc(string name, logic [9:0] want);
    #2 check(name, act, want);
    @(posedge clk);
    #1;
  endtask
  initial begin : stim
    logic [9:0] ld, hd, fl, flb;
    int r;
    ld = pk(1, 1, 1, 1, 0, 0, 0);
    hd = pk(0, 0, 0, 0, 0, 1, 0);
    fl = pk(0, 0, 2, 0, 0, 0, 0);
    flb = pk(0, 0, 2, 0, 0, 0, 1);
    @(posedge clk); #1;
    cyc("reset", '0);
    rstn = 1;
    repeat (3) cyc("idle", ld);
    de_wait_time = 4;
    cyc("w4_1", fl); cyc("w4_2", flb); cyc("w4_3", flb);
    cyc("w4_done", pk(1, 1, 1, 1, 0, 0, 1));
    de_wait_time = 1;
    cyc("w4_after", ld);
    de_rw = 2'b01; de_rd = 7; d_rs = 6'd7; d_uses_rs = 1;
    cyc("raw_rs", pk(0, 2, 1, 0, 0, 0, 0));
    de_rw = 2'b00;
    cyc("raw_gone", ld);
    d_uses_rs = 0; de_rw = 2'b10; de_rd = 3; d_rt = 6'h23; d_uses_rt = 1;
    cyc("raw_rt_file1", pk(0, 2, 1, 0, 0, 0, 0));
    d_rt = 6'h03;
    cyc("raw_file_mismatch", ld);
    d_uses_rt = 0; de_rw = 2'b01; de_rd = 7; d_uses_rs = 1; de_redirect = 1;
    cyc("redir_over_raw", pk(2, 2, 1, 1, 1, 0, 0));
    de_rw = 2'b00; d_uses_rs = 0; de_stop = 1;
    cyc("stop_over_redir", pk(2, 2, 1, 0, 0, 0, 0));
    de_stop = 0; de_redirect = 0;
    cyc("halt1", hd); cyc("halt2", hd);
    ext_stall = 1;
    cyc("halt_stall", hd);
    ext_stall = 0; resume = 1;
    cyc("halt_resume", hd);
    resume = 0;
    cyc("post_resume", ld);
    de_wait_time = 3;
    cyc("st_1", fl);
    ext_stall = 1;
    cyc("st_2", pk(0, 0, 0, 0, 0, 0, 1)); cyc("st_3", pk(0, 0, 0, 0, 0, 0, 1));
    ext_stall = 0;
    cyc("st_4", flb);
    cyc("st_5", pk(1, 1, 1, 1, 0, 0, 1));
    de_wait_time = 2;
    cyc("fin_1", fl);
    ext_stall = 1;
    cyc("fin_stall", pk(0, 0, 0, 0, 0, 0, 1));
    ext_stall = 0;
    cyc("fin_done", pk(1, 1, 1, 1, 0, 0, 1));
    de_wait_time = 0;
    cyc("wait0", ld);
    de_wait_time = 5;
    cyc("rm_1", fl); cyc("rm_2", flb);
    rstn = 0;
    cyc("rm_reset", '0);
    rstn = 1; de_wait_time = 1;
    cyc("rm_run", ld);
    de_wait_time = 31;
    cyc("w31_1", fl);
    repeat (29) cyc("w31_mid", flb);
    cyc("w31_done", pk(1, 1, 1, 1, 0, 0, 1));
    de_wait_time = 1;
    cyc("w31_after", ld);
    repeat (4000) begin
      r = $urandom_range(0, 99);
      de_wait_time = r < 70 ? 5'd1 : r < 80 ? 5'd0 : r < 97 ? 5'($urandom_range(2, 6)) : 5'd31;
      rstn = $urandom_range(0, 99) != 0;
      ext_stall = $urandom_range(0, 99) < 15;
      resume = $urandom_range(0, 99) < 20;
      de_stop = $urandom_range(0, 99) < 3;
      de_redirect = $urandom_range(0, 99) < 10;
      de_rw = 2'($urandom_range(0, 3));
      de_rd = 5'($urandom_range(0, 3));
      d_rs = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      d_rt = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      d_uses_rs = 1'($urandom_range(0, 1));
      d_uses_rt = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
